// File: rtl/frame_packer.sv
// frame_packer: collects a frame of 16-bit payload words from a valid/ready
// upstream, then writes header {SYNC, len}, the payload and a 16-bit
// additive checksum into a dual-clock word buffer, one write every other cycle.
module frame_packer #(
  parameter int unsigned MAX_LEN = 16,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  input  logic        buffer_full,
  output logic [15:0] data_1,
  output logic        data_1_en,
  output logic        busy,
  output logic        trunc_err,
  output logic [15:0] frame_count
);

  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  LenMax = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StHdr,
    StPay,
    StCsum
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] data_1_q, data_1_d;
  logic        data_1_en_q, data_1_en_d;
  logic        trunc_err_q, trunc_err_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [15:0] store_q [MAX_LEN];

  logic        accept;
  logic        frame_end;
  logic        write_ok;
  logic        pay_last;
  logic [7:0]  len_base;
  logic [7:0]  len_next;
  logic [15:0] sum_base;
  logic [15:0] emit_word;

  // Per-frame accumulators restart on the first word accepted in IDLE.
  always_comb begin
    len_base  = (state_q == StIdle) ? 8'd0 : len_q;
    sum_base  = (state_q == StIdle) ? 16'd0 : sum_q;
    len_next  = len_base + 8'd1;
    accept    = in_valid && in_ready;
    frame_end = in_last || (len_next == LenMax);
    pay_last  = (idx_q == (len_q - 8'd1));
  end

  // State register.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: collect until last/full, then header, payload, checksum.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = frame_end ? StHdr : StCollect;
      StCollect: if (accept && frame_end) state_d = StHdr;
      StHdr:     if (write_ok) state_d = StPay;
      StPay:     if (write_ok && pay_last) state_d = StCsum;
      StCsum:    if (write_ok) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State-decoded outputs; a write cycle always forces the following cycle idle.
  always_comb begin
    in_ready = (state_q == StIdle) || (state_q == StCollect);
    busy     = (state_q != StIdle);
    write_ok = ((state_q == StHdr) || (state_q == StPay) || (state_q == StCsum)) &&
               !data_1_en_q && !buffer_full;
  end

  // Select the word for the current emit state.
  always_comb begin
    unique case (state_q)
      StHdr:   emit_word = {SYNC, len_q};
      StPay:   emit_word = store_q[idx_q[IdxW-1:0]];
      default: emit_word = sum_q;
    endcase
  end

  // Datapath next-state: accumulate on accept, register a word on each write.
  always_comb begin
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    data_1_d      = data_1_q;
    data_1_en_d   = 1'b0;
    trunc_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    if (accept) begin
      len_d       = len_next;
      sum_d       = sum_base + in_data;
      trunc_err_d = frame_end && !in_last;
    end
    if (write_ok) begin
      data_1_en_d = 1'b1;
      data_1_d    = emit_word;
      unique case (state_q)
        StHdr:   idx_d = 8'd0;
        StPay:   idx_d = idx_q + 8'd1;
        StCsum:  frame_count_d = frame_count_q + 16'd1;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      data_1_q      <= '0;
      data_1_en_q   <= 1'b0;
      trunc_err_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      len_q         <= len_d;
      idx_q         <= idx_d;
      sum_q         <= sum_d;
      data_1_q      <= data_1_d;
      data_1_en_q   <= data_1_en_d;
      trunc_err_q   <= trunc_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Payload store; contents are only read below len, so no reset is needed.
  always_ff @(posedge clk_1) begin
    if (accept) begin
      store_q[len_base[IdxW-1:0]] <= in_data;
    end
  end

  assign data_1      = data_1_q;
  assign data_1_en   = data_1_en_q;
  assign trunc_err   = trunc_err_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_packer.sv
// Bench for frame_packer: drives upstream frames, captures buffer writes and
// compares them with a frame-level model built from the word/last stream.
module tb_frame_packer;

  localparam int unsigned MaxLen = 16;

  logic        clk_1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        buffer_full;
  logic [15:0] data_1;
  logic        data_1_en;
  logic        busy;
  logic        trunc_err;
  logic [15:0] frame_count;

  frame_packer #(.MAX_LEN(MaxLen), .SYNC(8'hA5)) dut (
    .clk_1       (clk_1),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .buffer_full (buffer_full),
    .data_1      (data_1),
    .data_1_en   (data_1_en),
    .busy        (busy),
    .trunc_err   (trunc_err),
    .frame_count (frame_count)
  );

  always #5 clk_1 = ~clk_1;

  int checks = 0;
  int errors = 0;

  // Buffer-full source: forced by a test or randomly toggled.
  logic force_full = 1'b0;
  logic rand_bp = 1'b0;
  logic bp_rnd = 1'b0;
  always @(negedge clk_1) bp_rnd <= ($urandom_range(0, 2) == 0);
  assign buffer_full = force_full | (rand_bp & bp_rnd);

  // Monitor: samples just after each rising edge.
  int          cyc = 0;
  logic [15:0] cap[$];
  int          cap_t[$];
  int          trunc_cnt = 0;
  int          adj_err = 0;
  int          stab_err = 0;
  logic        prev_en = 1'b0;
  logic [15:0] prev_data = '0;
  always @(posedge clk_1) begin
    #1;
    cyc++;
    if (!rst_n) begin
      prev_en   = 1'b0;
      prev_data = data_1;
    end else begin
      if (data_1_en) begin
        cap.push_back(data_1);
        cap_t.push_back(cyc);
        if (prev_en) adj_err++;
      end else if (data_1 !== prev_data) begin
        stab_err++;
      end
      if (trunc_err) trunc_cnt++;
      prev_en   = data_1_en;
      prev_data = data_1;
    end
  end

  // Stimulus and reference model.
  logic [15:0] stim_data[$];
  bit          stim_last[$];
  logic [15:0] exp_q[$];
  int          exp_frames = 0;
  int          exp_trunc = 0;

  task automatic clear_test();
    cap.delete();
    cap_t.delete();
    exp_q.delete();
    stim_data.delete();
    stim_last.delete();
    trunc_cnt = 0;
    exp_trunc = 0;
  endtask

  task automatic push(input logic [15:0] d, input bit l);
    stim_data.push_back(d);
    stim_last.push_back(l);
  endtask

  // Frames close on last or at MaxLen words; each yields header, payload, sum.
  task automatic model_stim();
    logic [15:0] fr[$];
    logic [15:0] s;
    foreach (stim_data[i]) begin
      fr.push_back(stim_data[i]);
      if (stim_last[i] || fr.size() == MaxLen) begin
        if (!stim_last[i]) exp_trunc++;
        exp_q.push_back({8'hA5, 8'(fr.size())});
        s = 16'd0;
        foreach (fr[j]) begin
          exp_q.push_back(fr[j]);
          s = s + fr[j];
        end
        exp_q.push_back(s);
        exp_frames++;
        fr.delete();
      end
    end
  endtask

  // Drives the stimulus queue; returns at the falling edge after the last accept.
  task automatic drive_stim(input int gap_max);
    int n;
    int k;
    foreach (stim_data[i]) begin
      k = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (k > 0) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (k) @(negedge clk_1);
      end
      in_valid = 1'b1;
      in_data  = stim_data[i];
      in_last  = stim_last[i];
      n = 0;
      while (!in_ready && n < 300) begin
        @(negedge clk_1);
        n++;
      end
      if (n >= 300) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout word %0d in_ready=%0b want 1", i, in_ready);
      end
      @(negedge clk_1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk_1);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout busy=%0b want 0", busy);
    end
    @(negedge clk_1);
  endtask

  task automatic wait_cap(input int num);
    int n = 0;
    while (cap.size() < num && n < 300) begin
      @(negedge clk_1);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL write_timeout got %0d writes want %0d", cap.size(), num);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_1);
    checks++;
    if (data_1 !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data got %h want 0000", data_1);
    end
    checks++;
    if (data_1_en !== 1'b0 || trunc_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes got en=%0b trunc=%0b want 0 0", data_1_en, trunc_err);
    end
    checks++;
    if (frame_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", frame_count);
    end
    rst_n = 1'b1;
    @(negedge clk_1);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got ready=%0b busy=%0b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int ready_bad = 0;
    int n = 0;
    clear_test();
    push(16'h0001, 0);
    push(16'h0002, 0);
    push(16'h0003, 1);
    model_stim();
    drive_stim(0);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1 || data_1_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_hdr_state got ready=%0b busy=%0b en=%0b want 0 1 0",
               in_ready, busy, data_1_en);
    end
    @(negedge clk_1);
    checks++;
    if (data_1_en !== 1'b1 || data_1 !== 16'hA503) begin
      errors++;
      $display("FAIL basic_hdr_latency got en=%0b data=%h want 1 a503", data_1_en, data_1);
    end
    while (cap.size() < 5 && n < 100) begin
      if (in_ready !== 1'b0) ready_bad++;
      @(negedge clk_1);
      n++;
    end
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL basic_ready_low got %0d ready cycles want 0", ready_bad);
    end
    wait_idle();
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
      checks++;
      if (cap_t[4] - cap_t[0] != 2 * (3 + 2) - 2) begin
        errors++;
        $display("FAIL basic_span got %0d want %0d", cap_t[4] - cap_t[0], 2 * (3 + 2) - 2);
      end
    end
    checks++;
    if (frame_count !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL basic_frame_count got %0d want %0d", frame_count, exp_frames);
    end
  endtask

  task automatic test_single();
    clear_test();
    push(16'hFFFF, 1);
    model_stim();
    drive_stim(0);
    wait_idle();
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL single_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || frame_count !== 16'(exp_frames)) begin
      errors++;
      $display("FAIL single_idle got busy=%0b count=%0d want 0 %0d", busy, frame_count,
               exp_frames);
    end
  endtask

  task automatic test_wrap();
    clear_test();
    push(16'h8000, 0);
    push(16'h8001, 1);
    model_stim();
    drive_stim(0);
    wait_idle();
    checks++;
    if (cap.size() != 4) begin
      errors++;
      $display("FAIL wrap_count got %0d words want 4", cap.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL wrap_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
      checks++;
      if (cap[3] !== 16'h0001) begin
        errors++;
        $display("FAIL wrap_csum got %h want 0001", cap[3]);
      end
    end
  endtask

  task automatic test_trunc();
    clear_test();
    for (int i = 0; i < 20; i++) push(16'($urandom), (i == 19));
    model_stim();
    drive_stim(0);
    wait_idle();
    checks++;
    if (trunc_cnt != exp_trunc) begin
      errors++;
      $display("FAIL trunc_pulse got %0d pulses want %0d", trunc_cnt, exp_trunc);
    end
    checks++;
    if (cap.size() != exp_q.size() || cap.size() < 19) begin
      errors++;
      $display("FAIL trunc_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL trunc_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
      checks++;
      if (cap[0] !== 16'hA510 || cap[18] !== 16'hA504) begin
        errors++;
        $display("FAIL trunc_headers got %h %h want a510 a504", cap[0], cap[18]);
      end
    end
  endtask

  task automatic test_backpressure();
    int          n0;
    logic [15:0] d0;
    bit          stable = 1'b1;
    clear_test();
    for (int i = 0; i < 6; i++) push(16'($urandom), (i == 5));
    model_stim();
    drive_stim(0);
    wait_cap(3);
    force_full = 1'b1;
    n0 = cap.size();
    d0 = data_1;
    repeat (10) begin
      @(negedge clk_1);
      if (cap.size() != n0 || data_1 !== d0) stable = 1'b0;
    end
    force_full = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold got writes=%0d data=%h want %0d %h", cap.size(), data_1, n0, d0);
    end
    wait_idle();
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n0;
    clear_test();
    for (int i = 0; i < 6; i++) push(16'($urandom), (i == 5));
    drive_stim(0);
    wait_cap(3);
    rst_n = 1'b0;
    #1;
    checks++;
    if (data_1_en !== 1'b0 || data_1 !== 16'h0000 || trunc_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got en=%0b data=%h trunc=%0b want 0 0000 0",
               data_1_en, data_1, trunc_err);
    end
    checks++;
    if (busy !== 1'b0 || frame_count !== 16'd0) begin
      errors++;
      $display("FAIL rstmid_state got busy=%0b count=%0d want 0 0", busy, frame_count);
    end
    repeat (2) @(negedge clk_1);
    rst_n = 1'b1;
    exp_frames = 0;
    n0 = cap.size();
    repeat (20) @(negedge clk_1);
    checks++;
    if (cap.size() != n0) begin
      errors++;
      $display("FAIL rstmid_quiet got %0d writes want %0d", cap.size(), n0);
    end
    clear_test();
    for (int i = 0; i < 3; i++) push(16'($urandom), (i == 2));
    model_stim();
    drive_stim(0);
    wait_idle();
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rstmid_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (frame_count !== 16'd1) begin
      errors++;
      $display("FAIL rstmid_frame_count got %0d want 1", frame_count);
    end
  endtask

  task automatic test_random();
    int len;
    clear_test();
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) push(16'($urandom), (i == len - 1));
    end
    model_stim();
    rand_bp = 1'b1;
    drive_stim(2);
    wait_idle();
    rand_bp = 1'b0;
    checks++;
    if (cap.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count got %0d words want %0d", cap.size(), exp_q.size());
    end else begin
      foreach (cap[i]) begin
        checks++;
        if (cap[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_word[%0d] got %h want %h", i, cap[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (frame_count !== 16'(exp_frames) || trunc_cnt != exp_trunc) begin
      errors++;
      $display("FAIL rand_counts got frames=%0d trunc=%0d want %0d %0d", frame_count,
               trunc_cnt, exp_frames, exp_trunc);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (adj_err != 0) begin
      errors++;
      $display("FAIL proto_adjacent got %0d back-to-back strobes want 0", adj_err);
    end
    checks++;
    if (stab_err != 0) begin
      errors++;
      $display("FAIL proto_hold got %0d data changes without strobe want 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_wrap();
    test_trunc();
    test_backpressure();
    test_random();
    test_reset_mid();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
